// File: rtl/decomp_pkg.sv
// Shared types, default widths and the scale-to-shift encoder used by both
// the scalar and the multi-lane weight decompressors.
package decomp_pkg;

  typedef enum logic {
    GENERAL = 1'b0,
    LEGACY  = 1'b1
  } decomp_mode_e;

  localparam int DEF_LANES   = 4;
  localparam int DEF_IN_W    = 8;
  localparam int DEF_OUT_W   = 32;
  localparam int DEF_SCALE_W = 32;
  localparam int DEF_NUM_CH  = 16;
  localparam int DEF_CNT_W   = 16;
  localparam int SH_BITS     = $clog2(DEF_SCALE_W);

  // Legacy encoding only ever recognised the five shift amounts below.
  function automatic logic [SH_BITS-1:0] scale_to_shift(
    input logic [DEF_SCALE_W-1:0] scale,
    input decomp_mode_e           mode
  );
    logic [SH_BITS-1:0] sh;
    sh = '0;
    if (mode == LEGACY) begin
      if (scale[16])     sh = SH_BITS'(16);
      else if (scale[8]) sh = SH_BITS'(8);
      else if (scale[4]) sh = SH_BITS'(4);
      else if (scale[2]) sh = SH_BITS'(2);
      else if (scale[1]) sh = SH_BITS'(1);
    end else begin
      for (int i = 0; i < DEF_SCALE_W; i++) begin
        if (scale[i]) sh = SH_BITS'(i);
      end
    end
    return sh;
  endfunction

endpackage

// File: rtl/decomp_lane.sv
// One lane of the shift/clamp stage: shifts a sign-extended weight and
// flags (and optionally saturates) results that do not fit in OUT_W bits.
module decomp_lane
  import decomp_pkg::*;
#(
  parameter int OUT_W   = DEF_OUT_W,
  parameter int SCALE_W = DEF_SCALE_W,
  parameter int SH_W    = $clog2(SCALE_W)
) (
  input  logic [OUT_W-1:0] w,
  input  logic [SH_W-1:0]  sh,
  input  logic             sat_en,
  output logic [OUT_W-1:0] res,
  output logic             ovf
);

  localparam int FW = OUT_W + SCALE_W;

  logic [FW-1:0]      full;
  logic [FW-OUT_W:0]  hi;

  assign full = {{SCALE_W{w[OUT_W-1]}}, w} << sh;
  // In range only when every bit from the result MSB upward matches the sign.
  assign hi   = full[FW-1:OUT_W-1];
  assign ovf  = !((&hi) || !(|hi));

  always_comb begin
    res = full[OUT_W-1:0];
    if (ovf && sat_en) begin
      res = full[FW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/weight_stream_decompressor.sv
// Two-stage multi-lane INT8 weight decompressor: per-channel scale lookup and
// shift encode in S1, per-lane shift/overflow handling in S2.
module weight_stream_decompressor
  import decomp_pkg::*;
#(
  parameter int LANES   = DEF_LANES,
  parameter int IN_W    = DEF_IN_W,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int SCALE_W = DEF_SCALE_W,
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int CH_W    = $clog2(NUM_CH),
  parameter int SH_W    = $clog2(SCALE_W),
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [CH_W-1:0]        cfg_ch,
  input  logic [SCALE_W-1:0]     cfg_scale,
  input  logic                   cfg_legacy,
  input  logic                   cfg_sat_en,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CH_W-1:0]        in_ch,
  input  logic [LANES*IN_W-1:0]  in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic [LANES-1:0]       out_sat,
  output logic [CH_W-1:0]        out_ch,
  output logic [CNT_W-1:0]       sat_count,
  input  logic                   sat_count_clr
);

  localparam int POP_W = $clog2(LANES + 1);
  localparam int SUM_W = CNT_W + 1;

  logic [SCALE_W-1:0]     scale_tbl [NUM_CH];
  logic [SH_W-1:0]        lookup_sh;

  logic                   s1_valid;
  logic [CH_W-1:0]        s1_ch;
  logic [SH_W-1:0]        s1_sh;
  logic [OUT_W-1:0]       s1_w [LANES];
  logic                   s2_valid;

  logic                   s1_adv;
  logic                   s2_adv;
  logic [LANES*OUT_W-1:0] lane_res;
  logic [LANES-1:0]       lane_ovf;

  logic [POP_W-1:0]       pop;
  logic [SUM_W-1:0]       sum;
  logic [CNT_W-1:0]       cnt_next;

  assign s2_adv    = !s2_valid || out_ready;
  assign s1_adv    = !s1_valid || s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid;

  // Registered table: a same-cycle write to the looked-up channel is not seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) scale_tbl[i] <= '0;
    end else if (cfg_we) begin
      scale_tbl[cfg_ch] <= cfg_scale;
    end
  end

  assign lookup_sh = scale_to_shift(scale_tbl[in_ch], decomp_mode_e'(cfg_legacy));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_ch    <= '0;
      s1_sh    <= '0;
      for (int l = 0; l < LANES; l++) s1_w[l] <= '0;
      s2_valid <= 1'b0;
      out_data <= '0;
      out_sat  <= '0;
      out_ch   <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_ch <= in_ch;
          s1_sh <= lookup_sh;
          for (int l = 0; l < LANES; l++) begin
            s1_w[l] <= {{(OUT_W-IN_W){in_data[l*IN_W+IN_W-1]}}, in_data[l*IN_W +: IN_W]};
          end
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= lane_res;
          out_sat  <= lane_ovf;
          out_ch   <= s1_ch;
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    decomp_lane #(
      .OUT_W   (OUT_W),
      .SCALE_W (SCALE_W),
      .SH_W    (SH_W)
    ) u_lane (
      .w      (s1_w[l]),
      .sh     (s1_sh),
      .sat_en (cfg_sat_en),
      .res    (lane_res[l*OUT_W +: OUT_W]),
      .ovf    (lane_ovf[l])
    );
  end

  always_comb begin
    pop = '0;
    for (int l = 0; l < LANES; l++) pop = pop + POP_W'(out_sat[l]);
    sum      = {1'b0, sat_count} + SUM_W'(pop);
    cnt_next = sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (sat_count_clr) begin
      sat_count <= '0;
    end else if (s2_valid && out_ready) begin
      sat_count <= cnt_next;
    end
  end

endmodule
